// File: rtl/calc1_pkg.sv
// Shared encodings for the calc1 command port: commands, response codes
// and the responder FSM states.
package calc1_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_ERR  = 2'd2
   } resp_e;

   typedef enum logic [1:0] {
      IDLE,
      OPND2,
      EXEC,
      RESP
   } state_e;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 datapath: unsigned add/sub with range errors and
// logical shifts by the 5 LSBs of op2. Errors force a zero result.
module calc1_alu
   import calc1_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CMD_W  = 4
) (
   input  logic [0:CMD_W-1]  cmd,
   input  logic [0:DATA_W-1] op1,
   input  logic [0:DATA_W-1] op2,
   output logic [0:DATA_W-1] result,
   output logic              err
);

   logic [0:DATA_W] sum;
   logic [0:4]      amt;

   always_comb begin
      sum    = {1'b0, op1} + {1'b0, op2};
      amt    = op2[DATA_W-5:DATA_W-1];
      result = '0;
      err    = 1'b0;
      case (cmd)
         CMD_W'(CMD_ADD): begin
            // index 0 of sum is the carry-out
            if (sum[0]) err = 1'b1;
            else        result = sum[1:DATA_W];
         end
         CMD_W'(CMD_SUB): begin
            if (op2 > op1) err = 1'b1;
            else           result = op1 - op2;
         end
         CMD_W'(CMD_SHL): result = op1 << amt;
         CMD_W'(CMD_SHR): result = op1 >> amt;
         default:         err = 1'b1;
      endcase
   end

endmodule

// File: rtl/calc1_resp_port.sv
// Responder end of the calc1 command port: captures command/op1, then op2,
// waits LATENCY cycles and presents a one-cycle response.
module calc1_resp_port
   import calc1_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CMD_W   = 4,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [0:CMD_W-1]  cmd_in,
   input  logic [0:DATA_W-1] data_in,
   output logic [0:1]        resp_out,
   output logic [0:DATA_W-1] data_out,
   output logic              busy_out
);

   state_e            state;
   state_e            next;
   logic [0:CMD_W-1]  cmd_q;
   logic [0:DATA_W-1] op1_q;
   logic [0:DATA_W-1] op2_q;
   logic [3:0]        cnt;
   logic [0:1]        resp_q;
   logic [0:DATA_W-1] data_q;
   logic [0:DATA_W-1] alu_res;
   logic              alu_err;
   logic              capture;

   // A command is accepted in IDLE and also on the edge leaving RESP.
   assign capture = (cmd_in != '0) && ((state == IDLE) || (state == RESP));

   calc1_alu #(
      .DATA_W (DATA_W),
      .CMD_W  (CMD_W)
   ) u_alu (
      .cmd    (cmd_q),
      .op1    (op1_q),
      .op2    (op2_q),
      .result (alu_res),
      .err    (alu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cmd_q  <= '0;
         op1_q  <= '0;
         op2_q  <= '0;
         cnt    <= '0;
         resp_q <= '0;
         data_q <= '0;
      end else begin
         state <= next;
         if (capture) begin
            cmd_q <= cmd_in;
            op1_q <= data_in;
         end
         if (state == OPND2) begin
            op2_q <= data_in;
            cnt   <= 4'(LATENCY - 1);
         end else if ((state == EXEC) && (cnt != '0)) begin
            cnt <= cnt - 4'd1;
         end
         if (next == RESP) begin
            resp_q <= alu_err ? RESP_ERR : RESP_OK;
            data_q <= alu_res;
         end else begin
            resp_q <= '0;
            data_q <= '0;
         end
      end
   end

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (capture) next = OPND2;
         OPND2:   next = EXEC;
         EXEC:    if (cnt == '0) next = RESP;
         RESP:    next = capture ? OPND2 : IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      busy_out = (state != IDLE);
      resp_out = resp_q;
      data_out = data_q;
   end

endmodule

// File: tb/tb_calc1_resp_port.sv
// Self-checking bench for calc1_resp_port: directed operations with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_calc1_resp_port;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cmd_in = '0;
   logic [31:0] data_in = '0;
   logic [1:0]  resp_out;
   logic [31:0] data_out;
   logic        busy_out;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   calc1_resp_port #(
      .DATA_W  (32),
      .CMD_W   (4),
      .LATENCY (LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_in   (cmd_in),
      .data_in  (data_in),
      .resp_out (resp_out),
      .data_out (data_out),
      .busy_out (busy_out)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void calc(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                output logic [1:0] r, output logic [31:0] d);
      logic [32:0] s;
      r = 2'd1;
      d = '0;
      case (c)
         4'd1: begin
            s = {1'b0, x} + {1'b0, y};
            if (s[32]) r = 2'd2;
            else       d = s[31:0];
         end
         4'd2: if (y > x) r = 2'd2; else d = x - y;
         4'd5: d = x << y[4:0];
         4'd6: d = x >> y[4:0];
         default: r = 2'd2;
      endcase
   endfunction

   // Reference model: one command in flight, captured at edge a, op2 at a+1,
   // response visible after edge a+1+LAT, busy from edge a through a+1+LAT.
   bit          m_fl = 1'b0;
   int          m_k = 0;
   int          m_a = 0;
   logic [3:0]  m_cmd;
   logic [31:0] m_op1;
   logic [1:0]  m_r;
   logic [31:0] m_d;
   logic [1:0]  exp_r = '0;
   logic [31:0] exp_d = '0;
   logic        exp_b = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_fl  = 1'b0;
         exp_r = '0;
         exp_d = '0;
         exp_b = 1'b0;
      end else begin
         m_k++;
         if (m_fl && m_k == m_a + 1) begin
            calc(m_cmd, m_op1, data_in, m_r, m_d);
         end else if ((!m_fl || m_k > m_a + 1 + LAT) && cmd_in != 4'd0) begin
            m_fl  = 1'b1;
            m_a   = m_k;
            m_cmd = cmd_in;
            m_op1 = data_in;
         end else if (m_fl && m_k > m_a + 1 + LAT) begin
            m_fl = 1'b0;
         end
         exp_b = m_fl && (m_k >= m_a) && (m_k <= m_a + 1 + LAT);
         exp_r = (m_fl && m_k == m_a + 1 + LAT) ? m_r : 2'd0;
         exp_d = (m_fl && m_k == m_a + 1 + LAT) ? m_d : 32'd0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("cyc_resp", {30'd0, resp_out}, {30'd0, exp_r});
         check("cyc_data", data_out, exp_d);
         check("cyc_busy", {31'd0, busy_out}, {31'd0, exp_b});
      end
   end

   // Caller is at a negedge; returns at the negedge where the response shows.
   task automatic run_op(input logic [3:0] c, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] xr, input logic [31:0] xd, input string nm,
                         output int lat);
      bit seen = 1'b0;
      cmd_in  = c;
      data_in = d1;
      @(negedge clk);
      cmd_in  = 4'd0;
      data_in = d2;
      @(negedge clk);
      data_in = '0;
      lat = 0;
      for (int i = 0; i <= 20 && !seen; i++) begin
         if (resp_out != 2'd0) begin
            seen = 1'b1;
            lat  = i;
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no response expected resp %0d", nm, xr);
      end else begin
         check({nm, "_resp"}, {30'd0, resp_out}, {30'd0, xr});
         check({nm, "_data"}, data_out, xd);
      end
   endtask

   logic [3:0]  v_cmd [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd5, 4'd6, 4'd5, 4'd4};
   logic [31:0] v_a   [10] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd10, 32'd3, 32'd4,
                               32'd1, 32'h8000_0000, 32'hF, 32'd1};
   logic [31:0] v_b   [10] = '{32'd7, 32'd1, 32'd1, 32'd3, 32'd5, 32'd4,
                               32'd31, 32'd35, 32'd0, 32'd2};
   logic [1:0]  v_r   [10] = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
   logic [31:0] v_d   [10] = '{32'd12, 32'd0, 32'h8000_0000, 32'd7, 32'd0, 32'd0,
                               32'h8000_0000, 32'h1000_0000, 32'hF, 32'd0};

   initial begin
      int lat;
      int cnt;
      logic [31:0] last;

      repeat (2) @(negedge clk);
      check("rst_resp", {30'd0, resp_out}, 32'd0);
      check("rst_data", data_out, 32'd0);
      check("rst_busy", {31'd0, busy_out}, 32'd0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_op(v_cmd[i], v_a[i], v_b[i], v_r[i], v_d[i], $sformatf("vec%0d", i), lat);
         if (i == 0) check("vec0_latency", lat, 32'd3);
         @(negedge clk);
         check($sformatf("vec%0d_after_busy", i), {31'd0, busy_out}, 32'd0);
         check($sformatf("vec%0d_after_resp", i), {30'd0, resp_out}, 32'd0);
      end

      // Command presented during EXEC must be dropped
      cmd_in = 4'd1; data_in = 32'd5;
      @(negedge clk);
      cmd_in = 4'd0; data_in = 32'd7;
      @(negedge clk);
      cmd_in = 4'd1; data_in = 32'd9;
      @(negedge clk);
      cmd_in = 4'd0; data_in = 32'd0;
      cnt = 0;
      last = '0;
      for (int i = 0; i < 15; i++) begin
         if (resp_out != 2'd0) begin
            cnt++;
            last = data_out;
         end
         @(negedge clk);
      end
      check("busy_ignore_count", cnt, 32'd1);
      check("busy_ignore_data", last, 32'd12);

      // Back-to-back: second command driven in the RESP cycle
      run_op(4'd1, 32'd10, 32'd20, 2'd1, 32'd30, "b2b_first", lat);
      run_op(4'd2, 32'd50, 32'd8, 2'd1, 32'd42, "b2b_second", lat);
      check("b2b_second_latency", lat, 32'd3);
      @(negedge clk);

      // Reset during EXEC
      cmd_in = 4'd1; data_in = 32'd1;
      @(negedge clk);
      cmd_in = 4'd0; data_in = 32'd1;
      @(negedge clk);
      data_in = '0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy_out}, 32'd0);
      check("midrst_resp", {30'd0, resp_out}, 32'd0);
      check("midrst_data", data_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (resp_out != 2'd0) cnt++;
      end
      check("midrst_no_resp", cnt, 32'd0);
      run_op(4'd1, 32'd2, 32'd2, 2'd1, 32'd4, "post_rst_add", lat);
      @(negedge clk);
      @(negedge clk);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/calc1_resp_port.md
Name: calc1_resp_port

Overview:
- Responder end of the calc1 command port. The bench drives this interface as initiator.
- Accepts a 4-bit command with operand 1, then operand 2 on the next cycle.
- Computes add, subtract, shift-left or shift-right, then returns a one-cycle response code with result data.
- Sits behind the calc1 request port. One command in flight at a time.

Parameters:
- DATA_W, 32, operand/result width.
- CMD_W, 4, command field width.
- LATENCY, 3, cycles from operand-2 capture to the response cycle (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_in  in  [0:CMD_W-1]  command. 0 = no-op, 1 = add, 2 = sub, 5 = shift left, 6 = shift right; all others invalid.
- data_in  in  [0:DATA_W-1]  operand 1 in the command cycle, operand 2 in the following cycle.
- resp_out  out  [0:1]  0 = none, 1 = success, 2 = error (overflow, underflow or invalid command), 3 never driven.
- data_out  out  [0:DATA_W-1]  result, valid only when resp_out != 0.
- busy_out  out  1  high from the cycle after command capture through the response cycle.

Behaviour:
- Bit order: index 0 is the MSB. The shift amount is data_in[DATA_W-5:DATA_W-1], the 5 LSBs of operand 2.
- Reset (async assert, sync-deassert usage):
  - resp_out = 0, data_out = 0, busy_out = 0, FSM = IDLE, internal registers cleared.
  - Reset mid-operation discards the operation; no response is ever issued for it.
- FSM states:
  - IDLE: cmd_in != 0 at an edge -> latch cmd and op1, go to OPND2.
  - OPND2: latch op2 from data_in unconditionally (cmd_in ignored), load latency counter with LATENCY-1, go to EXEC.
  - EXEC: counter decrements each cycle; at 0 go to RESP. With LATENCY = 1, go directly to RESP.
  - RESP: drive resp_out/data_out for exactly one cycle, return to IDLE.
- Timing: command captured at edge N, op2 at edge N+1, response visible after edge N+1+LATENCY, cleared after the next edge.
- busy_out: high in OPND2, EXEC and RESP.
- Non-zero cmd_in while not in IDLE: ignored. It is not queued and produces no response.
- A new command may be captured on the edge that exits RESP, i.e. back-to-back operation with no idle cycle.
- Arithmetic on unsigned DATA_W values:
  - add: DATA_W+1-bit sum. Carry-out -> resp 2, data 0; else resp 1, data = sum.
  - sub: op2 > op1 -> resp 2, data 0; else resp 1, data = op1 - op2. Equal operands give 0 with resp 1.
  - shl / shr: logical, zero fill, amount 0..31. Always resp 1; bits shifted out are lost without error.
  - invalid cmd (3, 4, 7..15): op2 is still consumed and full latency still elapses; then resp 2, data 0.
- data_out is 0 in every non-RESP cycle.
- Result is computed combinationally from the latched operands and registered into the output on entry to RESP.

Decomposition:
- Shared package calc1_pkg:
  - Command encodings: CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR.
  - Response encodings: RESP_NONE, RESP_OK, RESP_ERR.
  - FSM state enum: IDLE, OPND2, EXEC, RESP.
- One sub-module, calc1_alu: combinational. Inputs cmd, op1, op2; outputs result and err flag.
- FSM, counter and output registers stay in calc1_resp_port.

Test Plan:
- Reset then add: cmd 1 / 5, then 7. With LATENCY 3: resp 1, data 12 at cycle N+4; next cycle resp 0, data 0, busy 0.
- Add overflow: 0xFFFFFFFF + 1 -> resp 2, data 0. Also 0x7FFFFFFF + 1 -> resp 1, data 0x80000000.
- Subtract: 10 - 3 -> resp 1, data 7. 3 - 5 -> resp 2, data 0. 4 - 4 -> resp 1, data 0.
- Shifts: shl 1 by 31 -> 0x80000000. shr 0x80000000 by 35 -> 0x10000000 (amount 3). shl 0xF by 0 -> 0xF. All resp 1.
- Invalid and busy:
  - cmd 4 -> resp 2, data 0 after full latency.
  - cmd 1 issued during EXEC -> ignored; exactly one response.
  - Back-to-back commands on the RESP exit edge -> both answered in order.
- Reset mid-operation: assert rst_n low during EXEC. Outputs go to 0 immediately, no response appears. A following add 2 + 2 -> resp 1, data 4.
